// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO word offsets,
// STATUS bit positions and the clear-sweep FSM encoding.
package dmem_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } dmem_state_t;

  // Word offsets (address[3:2]) inside the register window.
  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_CYCLE  = 2'd1;
  localparam logic [1:0] OFF_STORES = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int unsigned ST_MISALIGN = 0;
  localparam int unsigned ST_RANGE    = 1;
  localparam int unsigned ST_INIT     = 2;

endpackage

// File: rtl/dmem_ram_array.sv
// Word-addressed RAM: one synchronous write port, one asynchronous read port.
module dmem_ram_array #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: RAM with power-up clear sweep, plus a 4-word
// MMIO window (LED, cycle counter, store counter, sticky status).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic [31:0] read_data,
  output logic [15:0] led_out,
  output logic        init_done,
  output logic        err_irq
);

  localparam logic [31:0]       RAM_LIMIT = 32'(DEPTH * 4);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  dmem_state_t       state, state_next;
  logic [ADDR_W-1:0] clr_idx, clr_next;
  logic [31:0]       cycle_cnt, store_cnt;
  logic [1:0]        flags, flags_next, set_mask, clr_mask;
  logic [15:0]       led;

  logic              aligned, ram_hit, mmio_hit;
  logic [1:0]        mmio_off;
  logic [ADDR_W-1:0] word_idx;
  logic              cpu_ram_we, mmio_we;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_wdata, ram_rdata;

  assign aligned  = (address[1:0] == 2'b00);
  assign ram_hit  = (address < RAM_LIMIT);
  assign mmio_hit = (address[31:4] == MMIO_BASE[31:4]);
  assign mmio_off = address[3:2];
  assign word_idx = address[ADDR_W+1:2];

  assign init_done = (state == READY);
  assign led_out   = led;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_next;
    end
  end

  always_comb begin
    state_next = state;
    clr_next   = clr_idx;
    case (state)
      CLEAR: begin
        clr_next = clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) state_next = READY;
      end
      READY: state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  // The sweep owns the RAM write port until READY; CPU RAM stores are dropped meanwhile.
  always_comb begin
    cpu_ram_we = write_enable & aligned & ram_hit & (state == READY);
    mmio_we    = write_enable & aligned & mmio_hit;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_idx;
      ram_wdata = '0;
    end else begin
      ram_we    = cpu_ram_we;
      ram_waddr = word_idx;
      ram_wdata = write_data;
    end
  end

  dmem_ram_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (word_idx),
    .rdata (ram_rdata)
  );

  // New errors are OR'd in after the W1C clear so a same-cycle set wins.
  always_comb begin
    set_mask              = '0;
    set_mask[ST_MISALIGN] = write_enable & ~aligned;
    set_mask[ST_RANGE]    = write_enable & aligned & ~ram_hit & ~mmio_hit;
    clr_mask              = (mmio_we && mmio_off == OFF_STATUS) ? write_data[1:0] : '0;
    flags_next            = (flags & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led       <= '0;
      cycle_cnt <= '0;
      store_cnt <= '0;
      flags     <= '0;
      err_irq   <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (cpu_ram_we) store_cnt <= store_cnt + 1'b1;
      if (mmio_we && mmio_off == OFF_LED) led <= write_data[15:0];
      flags   <= flags_next;
      err_irq <= |flags_next;
    end
  end

  always_comb begin
    read_data = '0;
    if (ram_hit) begin
      read_data = (state == READY) ? ram_rdata : '0;
    end else if (mmio_hit) begin
      case (mmio_off)
        OFF_LED:    read_data = {16'h0000, led};
        OFF_CYCLE:  read_data = cycle_cnt;
        OFF_STORES: read_data = store_cnt;
        OFF_STATUS: read_data = {29'd0, init_done, flags};
        default:    read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with hand-computed expectations.
module tb_dmem_responder;

  localparam int unsigned DEPTH     = 64;
  localparam int unsigned ADDR_W    = 6;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_LED     = MMIO_BASE + 32'h0;
  localparam logic [31:0] A_CYCLE   = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_STORES  = MMIO_BASE + 32'h8;
  localparam logic [31:0] A_STATUS  = MMIO_BASE + 32'hC;
  localparam logic [31:0] A_OOR     = 32'(DEPTH * 4);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        write_enable = 1'b0;
  logic [31:0] read_data;
  logic [15:0] led_out;
  logic        init_done;
  logic        err_irq;

  int unsigned total = 0;
  int unsigned bad   = 0;

  dmem_responder #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_data    (read_data),
    .led_out      (led_out),
    .init_done    (init_done),
    .err_irq      (err_irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    write_enable = 1'b0;
    address      = a;
    #1;
    d = read_data;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address      = a;
    write_data   = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic wait_init(inout int unsigned n);
    while (!init_done && n < 4 * DEPTH) begin
      tick();
      n++;
    end
  endtask

  logic [31:0] d, c1, c2;
  int unsigned n;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_err_irq", 32'(err_irq), 32'd0);
    rd(A_CYCLE, d);
    check("rst_cycle", d, 32'd0);

    // Clear sweep length
    reset = 1'b0;
    n = 0;
    wait_init(n);
    check("sweep_len", n, DEPTH);
    rd(A_CYCLE, d);
    check("cycle_after_sweep", d, DEPTH);
    rd(32'h0, d);
    check("ram0_cleared", d, 32'd0);
    rd(32'h4, d);
    check("ram4_cleared", d, 32'd0);
    rd(A_OOR - 32'd4, d);
    check("ramtop_cleared", d, 32'd0);
    tick();

    // RAM store: same-cycle read sees old data
    address = 32'h40; write_data = 32'h1234_5678; write_enable = 1'b1;
    #1;
    check("store_old", read_data, 32'd0);
    tick();
    write_enable = 1'b0;
    rd(32'h40, d);
    check("store_new", d, 32'h1234_5678);
    rd(A_STORES, d);
    check("stores_1", d, 32'd1);

    // Misaligned store
    wr(32'h41, 32'hDEAD_BEEF);
    check("misalign_irq", 32'(err_irq), 32'd1);
    rd(A_STATUS, d);
    check("misalign_status", d, 32'h5);
    rd(32'h40, d);
    check("misalign_ram", d, 32'h1234_5678);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, d);
    check("w1c_status", d, 32'h4);
    check("w1c_irq", 32'(err_irq), 32'd0);

    // Out-of-range store, then clear bit1
    wr(A_OOR, 32'h1111_2222);
    rd(A_STATUS, d);
    check("oor_status", d, 32'h6);
    check("oor_irq", 32'(err_irq), 32'd1);
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, d);
    check("oor_w1c", d, 32'h4);

    // Store to a read-only counter
    wr(A_CYCLE, 32'h0);
    rd(A_STATUS, d);
    check("ro_status", d, 32'h4);
    check("ro_irq", 32'(err_irq), 32'd0);
    rd(A_STORES, d);
    check("ro_stores", d, 32'd1);
    tick();
    rd(A_CYCLE, c1);
    repeat (5) tick();
    rd(A_CYCLE, c2);
    check("cycle_delta", c2 - c1, 32'd5);

    // LED register
    wr(A_LED, 32'hABCD_F00F);
    check("led_out", 32'(led_out), 32'h0000_F00F);
    rd(A_LED, d);
    check("led_read", d, 32'h0000_F00F);
    rd(32'h8000_0000, d);
    check("unmapped_read", d, 32'd0);
    tick();

    // Reset halfway through a sweep restarts it
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (DEPTH / 2) tick();
    check("mid_init_done", 32'(init_done), 32'd0);
    rd(32'h40, d);
    check("clear_read_zero", d, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("restart_init_done", 32'(init_done), 32'd0);
    rd(A_CYCLE, d);
    check("restart_cycle", d, 32'd0);
    n = 0;
    repeat (10) tick();
    n = 10;
    wr(32'h0, 32'hFFFF_FFFF);
    n++;
    wr(A_LED, 32'h0000_0055);
    n++;
    check("clear_led", 32'(led_out), 32'h55);
    wait_init(n);
    check("restart_sweep_len", n, DEPTH);
    rd(32'h0, d);
    check("clear_store_dropped", d, 32'd0);
    rd(32'h40, d);
    check("reclear_40", d, 32'd0);
    rd(A_STORES, d);
    check("clear_not_counted", d, 32'd0);
    rd(A_STATUS, d);
    check("clear_status", d, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
